// File: rtl/nibble_alu_sequencer_if.sv
// Shared 4-bit adder bus: the sequencer (master) drives operand nibbles and
// carry-in, and the external 283-style adder (slave) returns sum and carry-out.
interface nibble_alu_sequencer_if;
    logic [3:0] adder_a;
    logic [3:0] adder_b;
    logic       adder_c0;
    logic [3:0] adder_s;
    logic       adder_c4;

    modport master (output adder_a, adder_b, adder_c0, input adder_s, adder_c4);
    modport slave  (input adder_a, adder_b, adder_c0, output adder_s, adder_c4);
endinterface

// File: rtl/nibble_alu_sequencer.sv
// Runs ADD/SUB/NEG/PASS over a WORD_WIDTH word through one external 4-bit adder,
// LS nibble first. Define NIBBLE_ALU_FLAGS_EN to add zero_flag/neg_flag outputs.
module nibble_alu_sequencer #(
    parameter int WORD_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WORD_WIDTH-1:0] operand_a,
    input  logic [WORD_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  carry_out,
`ifdef NIBBLE_ALU_FLAGS_EN
    output logic                  zero_flag,
    output logic                  neg_flag,
`endif
    nibble_alu_sequencer_if.master adder
);

    localparam int NIBBLES = WORD_WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [NIBBLES-1:0][3:0] word_t;

    state_t           state;
    logic [IDX_W-1:0] nib;
    logic [CNT_W-1:0] cnt;
    word_t            a_q;
    word_t            b_q;
    word_t            res_q;
    word_t            res_next;
    logic             carry_q;
    logic             last_nib;
    logic             settle_end;

    assign last_nib   = (nib == IDX_W'(NIBBLES - 1));
    assign settle_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign result     = res_q;

    // Result as it will look after this nibble's capture; used for the flags.
    always_comb begin
        res_next      = res_q;
        res_next[nib] = adder.adder_s;
    end

    always_comb begin
        adder.adder_a  = '0;
        adder.adder_b  = '0;
        adder.adder_c0 = 1'b0;
        if (state == RUN) begin
            adder.adder_a  = a_q[nib];
            adder.adder_b  = b_q[nib];
            adder.adder_c0 = carry_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nib       <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
`ifdef NIBBLE_ALU_FLAGS_EN
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        nib       <= '0;
                        cnt       <= '0;
                        res_q     <= '0;
                        carry_out <= 1'b0;
`ifdef NIBBLE_ALU_FLAGS_EN
                        zero_flag <= 1'b0;
                        neg_flag  <= 1'b0;
`endif
                        // Subtraction and negation are A + ~B + 1 with carry-in set.
                        case (op)
                            2'd0: begin a_q <= operand_a; b_q <= operand_b;  carry_q <= 1'b0; end
                            2'd1: begin a_q <= operand_a; b_q <= ~operand_b; carry_q <= 1'b1; end
                            2'd2: begin a_q <= '0;        b_q <= ~operand_b; carry_q <= 1'b1; end
                            default: begin a_q <= '0;     b_q <= operand_b;  carry_q <= 1'b0; end
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (settle_end) begin
                        res_q   <= res_next;
                        carry_q <= adder.adder_c4;
                        cnt     <= '0;
                        nib     <= nib + 1'b1;
                        if (last_nib) begin
                            nib       <= '0;
                            carry_out <= adder.adder_c4;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`ifdef NIBBLE_ALU_FLAGS_EN
                            zero_flag <= (res_next == '0);
                            neg_flag  <= res_next[NIBBLES-1][3];
`endif
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench: a default-configured sequencer on a zero-delay adder and a
// SETTLE_CYCLES=4 sequencer on an adder with three cycles of output delay.
module tb_nibble_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start2;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        busy, done, carry_out;
    logic [31:0] result;
    logic        busy2, done2, cout2;
    logic [31:0] result2;
`ifdef NIBBLE_ALU_FLAGS_EN
    logic        zero_flag, neg_flag, zero2, neg2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nibble_alu_sequencer_if bus0 ();
    nibble_alu_sequencer_if bus1 ();

    always #5 clk = ~clk;

    // Zero-delay behavioural 283.
    assign {bus0.adder_c4, bus0.adder_s} = 5'(bus0.adder_a) + 5'(bus0.adder_b) + 5'(bus0.adder_c0);

    // 283 whose outputs lag its inputs by three clocks.
    logic [4:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= 5'(bus1.adder_a) + 5'(bus1.adder_b) + 5'(bus1.adder_c0);
        d2 <= d1;
        d3 <= d2;
    end
    assign {bus1.adder_c4, bus1.adder_s} = d3;

    nibble_alu_sequencer #(.WORD_WIDTH(32), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(opa), .operand_b(opb),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
`ifdef NIBBLE_ALU_FLAGS_EN
        .zero_flag(zero_flag), .neg_flag(neg_flag),
`endif
        .adder(bus0.master)
    );

    nibble_alu_sequencer #(.WORD_WIDTH(32), .SETTLE_CYCLES(4)) dut_slow (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op),
        .operand_a(opa), .operand_b(opb),
        .busy(busy2), .done(done2), .result(result2), .carry_out(cout2),
`ifdef NIBBLE_ALU_FLAGS_EN
        .zero_flag(zero2), .neg_flag(neg2),
`endif
        .adder(bus1.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int busy_cyc);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = k;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic do_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_c);
        int dc, bc;
        run_op(o, a, b, dc, bc);
        check({tag, " done cycle"}, dc, 17);
        check({tag, " busy cycles"}, bc, 16);
        check({tag, " result"}, result, exp_r);
        check({tag, " carry_out"}, carry_out, exp_c);
`ifdef NIBBLE_ALU_FLAGS_EN
        check({tag, " zero_flag"}, zero_flag, exp_r == 32'h0);
        check({tag, " neg_flag"}, neg_flag, exp_r[31]);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount, dcyc;
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
        op = 2'd0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset carry_out", carry_out, 0);
        check("reset adder_a", bus0.adder_a, 0);
        check("reset adder_b", bus0.adder_b, 0);
        check("reset adder_c0", bus0.adder_c0, 0);
        check("reset slow busy", busy2, 0);
        check("reset slow result", result2, 0);
        reset_n = 1'b1;

        do_vec("add carry chain", 2'd0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0);
        @(negedge clk);
        check("done one cycle", done, 0);
        check("result held", result, 32'h00010000);
        check("idle adder_a", bus0.adder_a, 0);

        do_vec("sub 5-7", 2'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
        do_vec("sub 7-5", 2'd1, 32'd7, 32'd5, 32'h00000002, 1'b1);
        do_vec("neg 1", 2'd2, 32'hAAAA5555, 32'd1, 32'hFFFFFFFF, 1'b0);
        do_vec("pass", 2'd3, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0);
        do_vec("add wrap", 2'd0, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1);

        // Mid-run start pulse and operand changes must not disturb the operation.
        @(negedge clk);
        op = 2'd0; opa = 32'd1; opb = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'd1; opa = 32'h0000DEAD; opb = 32'h00000055; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0; dcyc = 0;
        for (int k = 6; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                dcyc = k;
            end
        end
        check("disturb done count", dcount, 1);
        check("disturb done cycle", dcyc, 17);
        check("disturb result", result, 32'd3);
        check("disturb carry_out", carry_out, 0);
        check("disturb idle busy", busy, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        op = 2'd0; opa = 32'h11111111; opb = 32'h22222222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("partial busy", busy, 1);
        check("partial result", result, 32'h00000033);
        check("partial adder_a", bus0.adder_a, 4'h1);
        check("partial adder_b", bus0.adder_b, 4'h2);
        reset_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort adder_a", bus0.adder_a, 0);
        check("abort adder_b", bus0.adder_b, 0);
        check("abort adder_c0", bus0.adder_c0, 0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort no activity", dcount, 0);
        reset_n = 1'b1;
        do_vec("after abort", 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);

        // Slow adder: inputs must hold for four cycles on every nibble.
        @(negedge clk);
        op = 2'd0; opa = 32'h0F0F0F0F; opb = 32'h01010101; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check($sformatf("slow a n%0d c%0d", n, c), bus1.adder_a, (n % 2 == 0) ? 4'hF : 4'h0);
                check($sformatf("slow b n%0d c%0d", n, c), bus1.adder_b, (n % 2 == 0) ? 4'h1 : 4'h0);
                check($sformatf("slow c0 n%0d c%0d", n, c), bus1.adder_c0, (n % 2 == 1) ? 1'b1 : 1'b0);
            end
        end
        @(negedge clk);
        check("slow done", done2, 1);
        check("slow result", result2, 32'h10101010);
        check("slow carry_out", cout2, 0);
        @(negedge clk);
        check("slow done pulse ends", done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_alu_sequencer.md
Name: nibble_alu_sequencer

Overview:
- Sequences one shared 4-bit adder (a TTL 283-style part) across a WORD_WIDTH-bit word, one nibble at a time, least significant nibble first.
- Latches the carry between nibbles and waits a programmable settle time on each nibble so the adder's propagation delay is respected.
- Gives the Manchester Baby datapath add, subtract, negate (LDN) and pass operations from a single 4-bit adder package.

Parameters:
- WORD_WIDTH, 32, operand/result width; must be a multiple of 4 and at least 4.
- SETTLE_CYCLES, 2, clock cycles adder inputs are held stable per nibble before the sum is captured; must be at least 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  0=ADD (A+B), 1=SUB (A-B), 2=NEG (-B), 3=PASS (B).
- operand_a  input  WORD_WIDTH  first operand; sampled with start.
- operand_b  input  WORD_WIDTH  second operand; sampled with start.
- busy  output  1  high while the sequence runs.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WORD_WIDTH  assembled sum; held until the next accepted start.
- carry_out  output  1  final nibble C4; for SUB, 1 means no borrow.
- adder_a  output  4  A nibble driven to the shared adder.
- adder_b  output  4  B nibble driven to the shared adder.
- adder_c0  output  1  carry-in driven to the shared adder.
- adder_s  input  4  sum returned from the adder.
- adder_c4  input  1  carry-out returned from the adder.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - busy, done, carry_out and result are 0.
  - Nibble index, settle counter, latched operands and carry register are 0.
  - The adder_* outputs are 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- Leaving IDLE: at a rising edge in IDLE with start=1, latch the operands according to op, clear the nibble index and settle counter, and enter RUN. The carry register loads the initial carry.
  - ADD: a=A, b=B, carry=0.
  - SUB: a=A, b=~B, carry=1.
  - NEG: a=0, b=~B, carry=1.
  - PASS: a=0, b=B, carry=0.
- RUN:
  - Drive adder_a = a[4i+3:4i], adder_b = b[4i+3:4i], adder_c0 = carry register, where i is the nibble index.
  - These outputs come combinationally from registers and are stable for the whole nibble.
  - The settle counter increments every cycle.
  - At the edge where counter == SETTLE_CYCLES-1:
    - result[4i+3:4i] <= adder_s.
    - carry register <= adder_c4.
    - The counter clears and i increments.
  - On the capture of the last nibble, carry_out <= adder_c4 and the state moves to DONE.
- busy = 1 exactly in RUN.
- Outside RUN, the adder_* outputs are 0.
- DONE: done=1 for exactly one cycle, then return to IDLE. result and carry_out hold until the next start is accepted.
- Latency: the start edge is followed by (WORD_WIDTH/4)*SETTLE_CYCLES RUN cycles, then the done cycle. With the defaults, done is high in the 17th cycle after the start edge.
- start while in RUN or DONE: ignored, no queuing. A start still held high in the IDLE cycle after DONE is accepted.
- op and operands are sampled only at acceptance. Changes during RUN have no effect.
- Accepting a new start clears result to 0 at the acceptance edge. Partial results are visible during RUN.
- reset_n low mid-RUN: operation abandoned immediately, all outputs return to reset values, no done pulse.
- Arithmetic is modulo 2^WORD_WIDTH. There is no signed overflow detection.

Optional Feature:
- Macro NIBBLE_ALU_FLAGS_EN.
- When defined, add two outputs, each 1 bit:
  - zero_flag: 1 when the final result == 0.
  - neg_flag: result[WORD_WIDTH-1].
- Both flags update on the same edge as the last nibble capture and hold with result. Both reset to 0 and both clear when a new start is accepted.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- ADD, A=0x0000FFFF, B=0x00000001, defaults, behavioural 4-bit adder model -> result=0x00010000, carry_out=0, busy high for 16 cycles, done pulses in cycle 17 after start.
- SUB, A=5, B=7 -> result=0xFFFFFFFE, carry_out=0. SUB, A=7, B=5 -> result=0x00000002, carry_out=1.
- NEG, B=1 -> 0xFFFFFFFF. PASS, B=0x12345678 -> 0x12345678. ADD, A=0xFFFFFFFF, B=1 -> result=0, carry_out=1 (zero_flag=1 with NIBBLE_ALU_FLAGS_EN).
- SETTLE_CYCLES=4, adder model with 3-cycle output delay, A=0x0F0F0F0F, B=0x01010101 -> result 0x10101010. Check adder_a/adder_b/adder_c0 stable for 4 cycles per nibble.
- start pulsed again in RUN, and op/operands changed mid-run -> no effect, single done, original result.
- reset_n low after the 5th RUN cycle -> busy/done/result/adder_* go 0 immediately. A later start completes normally.
